// File: rtl/sc_bitstream_counter.sv
// sc_bitstream_counter: converts a 1-bit stochastic stream into a binary
// ones count over a window of 2^WIDTH valid samples, with a valid/ready
// result handshake, one-shot or continuous windows and a sticky overrun.
// Optional macro SC_BITSTREAM_COUNTER_BIPOLAR_EN: when defined, the result
// is bipolar two's complement (2*ones - 2^WIDTH, saturated at +2^WIDTH-1).
module sc_bitstream_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             start,
  input  logic             continuous,
  output logic [WIDTH:0]   result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sample_cnt;
  logic [WIDTH-1:0] ones_cnt;
  logic             window_done;
  logic             accept;
  logic [WIDTH:0]   ones_total;
  logic [WIDTH:0]   window_result;

  // The last sample of a window is the valid one arriving at index 2^WIDTH-1.
  assign window_done = (state == ACCUM) && bit_valid && (sample_cnt == {WIDTH{1'b1}});
  assign accept      = out_valid && out_ready;
  // One extra bit so an all-ones window reports exactly 2^WIDTH.
  assign ones_total  = {1'b0, ones_cnt} + {{WIDTH{1'b0}}, bit_in};
  assign busy        = (state == ACCUM);

`ifdef SC_BITSTREAM_COUNTER_BIPOLAR_EN
  // Map ones count to 2*ones - 2^WIDTH, clamping the single unrepresentable case.
  always_comb begin
    window_result = {ones_total[WIDTH-1:0], 1'b0} - {1'b1, {WIDTH{1'b0}}};
    if (ones_total[WIDTH]) begin
      window_result = {1'b0, {WIDTH{1'b1}}};
    end
  end
`else
  assign window_result = ones_total;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: continuous is only looked at when a window closes.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = ACCUM;
        end
      end
      ACCUM: begin
        if (window_done && !continuous) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Window counters, result register, handshake and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      ones_cnt   <= '0;
      result     <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sample_cnt <= '0;
        ones_cnt   <= '0;
      end
      if (window_done) begin
        result     <= window_result;
        out_valid  <= 1'b1;
        sample_cnt <= '0;
        ones_cnt   <= '0;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end
      end else begin
        if (accept) begin
          out_valid <= 1'b0;
        end
        if (state == ACCUM && bit_valid) begin
          sample_cnt <= sample_cnt + WIDTH'(1);
          ones_cnt   <= ones_cnt + WIDTH'(bit_in);
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_bitstream_counter.sv
// Testbench for sc_bitstream_counter (WIDTH=4, 16-sample windows).
// Expected results are pushed to a scoreboard queue as windows are issued;
// a monitor pops and compares on every accepted handshake.
module tb_sc_bitstream_counter;

  localparam int W = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         bit_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         start = 1'b0;
  logic         continuous = 1'b0;
  logic         out_ready = 1'b0;
  logic [W:0]   result;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  int           total = 0;
  int           bad = 0;
  int           rdy_pct = 100;
  bit           exp_ovr = 1'b0;
  logic [W:0]   exp_q[$];

  sc_bitstream_counter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .start      (start),
    .continuous (continuous),
    .result     (result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Reference: a window's result follows directly from its number of ones.
  function automatic logic [W:0] exp_val(input int ones);
    int v;
`ifdef SC_BITSTREAM_COUNTER_BIPOLAR_EN
    if (ones == N) v = N - 1;
    else v = 2 * ones - N;
`else
    v = ones;
`endif
    return v[W:0];
  endfunction

  // Random 16-bit pattern with exactly n ones.
  function automatic logic [N-1:0] make_pat(input int n);
    logic [N-1:0] p;
    int cnt;
    int idx;
    p = '0;
    cnt = 0;
    while (cnt < n) begin
      idx = $urandom_range(0, N - 1);
      if (!p[idx]) begin
        p[idx] = 1'b1;
        cnt++;
      end
    end
    return p;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; on a window's last sample update the scoreboard.
  task automatic applyStimulus(input bit v, input bit b, input bit s, input bit c,
                               input bit r, input bit last, input int ones);
    bit_valid  = v;
    bit_in     = b;
    start      = s;
    continuous = c;
    rst        = r;
    out_ready  = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(1, 100) <= rdy_pct);
    if (last) begin
      if (exp_q.size() > 0 && !out_ready) begin
        exp_ovr = 1'b1;
        void'(exp_q.pop_back());
      end
      exp_q.push_back(exp_val(ones));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    exp_q.delete();
    exp_ovr = 1'b0;
    bit_valid = 1'b0;
    rst = 1'b0;
  endtask

  // gap_mode: 0 none, 1 one invalid cycle (bit_in=1) before each sample, 2 random gaps.
  task automatic send_window(input logic [N-1:0] pat, input int gap_mode, input bit cont);
    int ones;
    int k;
    ones = $countones(pat);
    for (int i = 0; i < N; i++) begin
      if (gap_mode == 1) begin
        applyStimulus(0, 1, 0, cont, 0, 0, 0);
      end else if (gap_mode == 2) begin
        k = 0;
        while (k < 3 && $urandom_range(0, 2) == 0) begin
          applyStimulus(0, 1'($urandom), 0, cont, 0, 0, 0);
          k++;
        end
      end
      applyStimulus(1, pat[i], 0, cont, 0, i == N - 1, ones);
    end
  endtask

  task automatic drain(input string name);
    rdy_pct = 100;
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput({name, "_pending"}, exp_q.size(), 0);
    checkOutput({name, "_valid_low"}, int'(out_valid), 0);
  endtask

  // Monitor: every accepted result must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got %0d expected none", result);
      end else begin
        checkOutput("scoreboard_result", int'(result), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bit cont;
    bit need_start;
    int ones;

    // Reset state
    do_reset();
    checkOutput("reset_result", int'(result), 0);
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_overrun", int'(overrun), 0);

    // One-shot 1010... pattern
    $display("[TB] one-shot alternating pattern");
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("start_busy", int'(busy), 1);
    send_window(16'hAAAA, 0, 0);
    checkOutput("oneshot_valid", int'(out_valid), 1);
    checkOutput("oneshot_result", int'(result), int'(exp_val(8)));
    drain("oneshot");
    checkOutput("oneshot_idle_busy", int'(busy), 0);

    // All-ones and all-zeros windows
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    send_window(16'hFFFF, 0, 0);
    checkOutput("all_ones_result", int'(result), int'(exp_val(16)));
    drain("all_ones");
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    send_window(16'h0000, 0, 0);
    checkOutput("all_zeros_result", int'(result), int'(exp_val(0)));
    drain("all_zeros");

    // Alternating bit_valid; invalid cycles carry bit_in=1
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    send_window(16'hFFFF, 1, 0);
    checkOutput("gapped_valid", int'(out_valid), 1);
    checkOutput("gapped_result", int'(result), int'(exp_val(16)));
    drain("gapped");

    // Continuous with stalled consumer: overrun
    $display("[TB] continuous overrun");
    rdy_pct = 0;
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    send_window(make_pat(4), 0, 1);
    send_window(make_pat(12), 0, 0);
    checkOutput("ovr_valid", int'(out_valid), 1);
    checkOutput("ovr_result", int'(result), int'(exp_val(12)));
    checkOutput("ovr_flag", int'(overrun), 1);
    drain("ovr");
    checkOutput("ovr_sticky", int'(overrun), 1);
    do_reset();
    checkOutput("ovr_cleared", int'(overrun), 0);

    // Continuous back-to-back with ready consumer
    $display("[TB] continuous back-to-back");
    rdy_pct = 100;
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    send_window(make_pat(3), 0, 1);
    checkOutput("b2b_busy", int'(busy), 1);
    send_window(make_pat(7), 0, 1);
    send_window(make_pat(11), 0, 0);
    drain("b2b");
    checkOutput("b2b_overrun", int'(overrun), 0);

    // Reset in the middle of a window
    $display("[TB] mid-window reset");
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    rst = 1'b0;
    checkOutput("midrst_valid", int'(out_valid), 0);
    checkOutput("midrst_result", int'(result), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    send_window(make_pat(5), 0, 0);
    checkOutput("midrst_new_result", int'(result), int'(exp_val(5)));
    drain("midrst");

    // Randomized windows, gaps, continuous and consumer stalls
    $display("[TB] randomized windows");
    do_reset();
    need_start = 1'b1;
    for (int n = 0; n < 10; n++) begin
      ones = $urandom_range(0, N);
      cont = (n == 9) ? 1'b0 : 1'($urandom);
      rdy_pct = 50;
      if (need_start) applyStimulus(0, 1'($urandom), 1, cont, 0, 0, 0);
      send_window(make_pat(ones), 2, cont);
      need_start = !cont;
      if (!cont) drain("rand");
    end
    checkOutput("rand_overrun", int'(overrun), int'(exp_ovr));
    checkOutput("rand_busy", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_bitstream_counter.md
Name: sc_bitstream_counter

Overview:
- Stochastic-to-binary converter sitting directly downstream of the bitstream averaging stage; consumes its 1-bit output stream.
- Counts ones over a fixed window of 2^WIDTH valid samples and presents the count as a binary result via a valid/ready handshake.
- Supports one-shot (start-triggered) and continuous back-to-back windows; reports overruns when the consumer stalls.

Parameters:
- WIDTH, 8, log2 of window length; window = 2^WIDTH valid samples; result is WIDTH+1 bits.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- bit_in  in  1  stochastic bitstream sample (averaging stage output)
- bit_valid  in  1  qualifies bit_in; sample ignored when 0 (window stalls)
- start  in  1  begin a window; sampled only in IDLE
- continuous  in  1  1 = restart a new window automatically after each completes
- result  out  WIDTH+1  ones count of last completed window (0..2^WIDTH)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result when out_valid && out_ready
- busy  out  1  high in ACCUM
- overrun  out  1  sticky; set when a window completes while previous result unaccepted

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; result=0, out_valid=0, busy=0, overrun=0; sample/ones counters cleared. Reset mid-window discards the partial count; no result produced.
- States: IDLE, ACCUM, HOLD.
- IDLE: start=1 -> ACCUM next cycle with sample_cnt=0, ones_cnt=0. bit_in ignored in IDLE.
- ACCUM: each cycle with bit_valid=1: sample_cnt+=1, ones_cnt+=bit_in. bit_valid=0: counters hold. start ignored.
- Window end: the cycle accepting sample index 2^WIDTH-1 with bit_valid=1; at that edge result <= ones_cnt+bit_in (WIDTH+1 bits, no wrap; all-ones stream gives exactly 2^WIDTH), out_valid <= 1. Latency: result visible the cycle after the last sample.
- After window end: continuous=1 -> remain ACCUM, counters cleared; the next cycle's sample counts toward the new window (no dead cycle). continuous=0 -> HOLD.
- HOLD: wait for handshake; on out_valid && out_ready -> IDLE, out_valid <= 0. start ignored in HOLD.
- Handshake: out_valid stays high, result stable, until accepted. Acceptance clears out_valid at next edge unless a new window completes in that same cycle (new result loaded, out_valid stays 1, no overrun).
- Overrun: window completes while out_valid=1 and out_ready=0 -> result overwritten with new count, out_valid stays 1, overrun <= 1 (cleared only by rst).
- continuous sampled only at window end; deasserting it mid-window finishes the current window then goes to HOLD.
- busy = (state==ACCUM).

Optional Feature:
- Macro SC_BITSTREAM_COUNTER_BIPOLAR_EN.
- Defined: result is bipolar two's complement, value = 2*ones - 2^WIDTH, saturated to +2^WIDTH-1 when ones=2^WIDTH (so fits WIDTH+1 signed bits); all-zeros stream gives -2^WIDTH. Handshake/overrun unchanged.
- Undefined: unipolar unsigned ones count as above; no saturation logic present.

Test Plan (WIDTH=4, window 16):
- rst, start pulse, 16 valid samples pattern 1010..., out_ready=1 -> out_valid one cycle after 16th sample, result=8, then IDLE, busy=0.
- All-ones 16 samples, one-shot -> result=16 (5'b10000); with BIPOLAR_EN result=+15 (saturated); all-zeros with BIPOLAR_EN -> result=-16.
- bit_valid toggled 0/1 every cycle, stream of ones -> window completes after 32 cycles, result=16; invalid-cycle bit_in=1 not counted.
- continuous=1, out_ready=0, two full windows (counts 4 then 12) -> after second window result=12, out_valid=1, overrun=1; out_ready=1 then -> accepted, overrun stays 1.
- continuous=1, out_ready=1, windows back-to-back with counts 3,7,11 -> three results in order, no gap sample lost, overrun=0.
- rst asserted after 9 samples of a window -> next cycle out_valid=0, result=0, IDLE; start then 16 samples of count 5 -> result=5.
